// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the CPU load/store path and the UART loader.
// CPU has fixed priority; a starvation counter forces UART slots; upg_mode hands memory to UART.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic              clock,
  input  logic              rst_n,
  input  logic              upg_mode,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              uart_req,
  input  logic              uart_we,
  input  logic [ADDR_W-1:0] uart_addr,
  input  logic [DATA_W-1:0] uart_wdata,
  output logic              uart_gnt,
  output logic              uart_rvalid,
  output logic [DATA_W-1:0] uart_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [CNT_W-1:0] StarveMax = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             rd_cpu_q, rd_cpu_d;
  logic             rd_uart_q, rd_uart_d;

  always_comb begin
    cpu_gnt  = 1'b0;
    uart_gnt = 1'b0;
    if (!rst_n) begin
      cpu_gnt  = 1'b0;
      uart_gnt = 1'b0;
    end else if (upg_mode) begin
      uart_gnt = uart_req;
    end else if (uart_req && (starve_cnt_q == StarveMax)) begin
      uart_gnt = 1'b1;
    end else if (cpu_req) begin
      cpu_gnt = 1'b1;
    end else if (uart_req) begin
      uart_gnt = 1'b1;
    end
  end

  // With no grant the memory port idles on the CPU inputs.
  always_comb begin
    if (uart_gnt) begin
      mem_addr  = uart_addr;
      mem_wdata = uart_wdata;
    end else begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
    mem_we = (cpu_gnt & cpu_we) | (uart_gnt & uart_we);
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    rd_cpu_d     = cpu_gnt & ~cpu_we;
    rd_uart_d    = uart_gnt & ~uart_we;
    if (!rst_n) begin
      starve_cnt_d = '0;
      rd_cpu_d     = 1'b0;
      rd_uart_d    = 1'b0;
    end else if (uart_gnt || !uart_req) begin
      starve_cnt_d = '0;
    end else if (!upg_mode && (starve_cnt_q != StarveMax)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    starve_cnt_q <= starve_cnt_d;
    rd_cpu_q     <= rd_cpu_d;
    rd_uart_q    <= rd_uart_d;
  end

  // Read word returns to whichever requester owned last cycle's read grant.
  always_comb begin
    cpu_rvalid  = rd_cpu_q;
    uart_rvalid = rd_uart_q;
    cpu_rdata   = rd_cpu_q ? mem_rdata : '0;
    uart_rdata  = rd_uart_q ? mem_rdata : '0;
  end

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single-port data memory (dmemory32: 32-bit word, 1-cycle synchronous read, write on clock edge) between two requesters:
  - the CPU load/store path;
  - the UART program/data loader.
- Sits between the MEM stage / UART loader and dmemory32, driving its address, write-data and write-enable inputs.
- Fixed CPU priority, a starvation guard for the UART side, and an exclusive upgrade mode.
- Routes each 1-cycle-late read word back to the requester that issued it.

Parameters:
ADDR_W, 32, address width of both requesters and memory
DATA_W, 32, data word width
STARVE_LIMIT, 4, consecutive denied UART cycles before UART is forced a slot (1..2^CNT_W-1)
CNT_W, 3, width of starvation counter

Ports:
clock  in  1  system clock, all state updates on rising edge
rst_n  in  1  synchronous reset, active-low
upg_mode  in  1  1 = UART loader owns memory exclusively
cpu_req  in  1  CPU access request
cpu_we  in  1  CPU write (1) / read (0)
cpu_addr  in  ADDR_W  CPU byte address
cpu_wdata  in  DATA_W  CPU write data
cpu_gnt  out  1  CPU access performed this cycle
cpu_rvalid  out  1  CPU read data valid this cycle
cpu_rdata  out  DATA_W  CPU read data
uart_req  in  1  UART loader access request
uart_we  in  1  UART write / read
uart_addr  in  ADDR_W  UART byte address
uart_wdata  in  DATA_W  UART write data
uart_gnt  out  1  UART access performed this cycle
uart_rvalid  out  1  UART read data valid this cycle
uart_rdata  out  DATA_W  UART read data
mem_addr  out  ADDR_W  to dmemory32 address
mem_wdata  out  DATA_W  to dmemory32 writeData
mem_we  out  1  to dmemory32 memWrite
mem_rdata  in  DATA_W  from dmemory32 readData (valid 1 cycle after address)

Behaviour:
- Grant is combinational, from current requests and registered state; at most one gnt high per cycle.
- Grant priority, evaluated in this order:
  1. rst_n=0: both gnt 0, mem_we 0.
  2. upg_mode=1: uart_gnt=uart_req; cpu_gnt=0. The CPU is stalled by the missing gnt.
  3. uart_req and starve_cnt==STARVE_LIMIT: uart_gnt=1, cpu_gnt=0.
  4. cpu_req: cpu_gnt=1.
  5. uart_req: uart_gnt=1.
  6. Otherwise: no grant.
- Memory mux:
  - mem_addr/mem_wdata come from the granted requester; with no grant they default to the CPU inputs.
  - mem_we = (cpu_gnt&cpu_we)|(uart_gnt&uart_we).
- Write: committed at the rising edge of the grant cycle; no rvalid is produced.
- Read, 1-cycle latency:
  - At the grant edge with we=0, register the owner flag (rd_cpu or rd_uart).
  - Next cycle the owner's rvalid=1 for exactly one cycle, and its rdata = mem_rdata.
  - A non-owner's rdata, or any rdata while rvalid=0, is 32'h0.
- Back-to-back reads: a grant every cycle yields rvalid every cycle. Ownership is tracked per cycle, so interleaving owners is legal.
- starve_cnt (CNT_W bits, reset 0):
  - +1 when uart_req & !uart_gnt & !upg_mode, saturating at STARVE_LIMIT;
  - cleared when uart_gnt=1 or uart_req=0.
- upg_mode toggle: takes effect in the same cycle. A read granted in the previous cycle still returns to its original owner.
- Reset (rst_n=0 sampled at an edge):
  - clears starve_cnt and both owner flags;
  - the next cycle shows both rvalid=0; a pending read return is dropped.
  - Registered outputs reset to 0: cpu_rvalid, uart_rvalid, cpu_rdata, uart_rdata.
- Requesters hold req/we/addr/wdata stable until gnt; the arbiter stores no request.

Test Plan:
- Reset: rst_n=0 for 2 cycles with cpu_req=1, cpu_we=1 -> cpu_gnt=0, mem_we=0, all rvalid=0 and rdata=0; no memory change at 0x0.
- CPU write then read: CPU writes 0x000000F5 to 0x04, then reads 0x04 -> cpu_gnt=1 each cycle; cpu_rvalid=1 one cycle after the read grant with cpu_rdata=0x000000F5; uart_rvalid stays 0.
- Contention/starvation: cpu_req held 1 (reads) and uart_req=1 write 0xA0000000 @0x10 from cycle 0 -> cpu_gnt in cycles 0-3, uart_gnt=1 in cycle 4 (starve_cnt=4), cpu_gnt again in cycle 5; readback @0x10 = 0xA0000000.
- Upgrade mode: upg_mode=1, UART writes 0x11111111..0x44444444 to 0x00..0x0C on consecutive cycles while cpu_req=1 -> cpu_gnt=0 throughout; then upg_mode=0 -> CPU reads return those four words in order.
- Interleaved reads: cycle n CPU reads 0x00, cycle n+1 starvation forces a UART read of 0x04 -> cpu_rvalid at n+1 with word @0x00, uart_rvalid at n+2 with word @0x04, never both high in the same cycle.
- Reset mid-read: CPU read granted at edge k, rst_n=0 sampled at edge k+1 -> cpu_rvalid=0 in the cycle after edge k+1; starve_cnt=0.
